// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned LANES  = 4;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [WORD_W-1:0] rdata;
        logic              err;
    } rsp_t;

    localparam rsp_t RSP_NONE = '{rdata: 32'h0000_0000, err: 1'b0};

endpackage

// File: rtl/dmem_ram_be.sv
// Word-addressed RAM: synchronous byte-lane writes, combinational read.
module dmem_ram_be
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic [LANES-1:0]               wr_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [WORD_W-1:0]              wdata,
    output logic [WORD_W-1:0]              rdata
);

    logic [WORD_W-1:0] mem_r [DEPTH_WORDS];

    // Write only the byte lanes whose enable is set; storage has no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(LANES); i++) begin
            if (wr_en[i]) begin
                mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, serviced from an internal
// RAM after LATENCY cycles, answered over a valid/ready response channel.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned       AW       = $clog2(DEPTH_WORDS);
    localparam logic [WORD_W-1:0] SPAN     = WORD_W'(DEPTH_WORDS * 4);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam bit                DIRECT   = (LATENCY <= 1);

    state_t             state_r, state_next_s;
    logic [CNT_W-1:0]   cnt_r, cnt_next_s;
    logic               we_r;
    logic [WORD_W-1:0]  addr_r, wdata_r;
    logic [LANES-1:0]   be_r;
    rsp_t               rsp_r, rsp_next_s, exec_rsp_s;
    logic               valid_r, valid_next_s;
    logic               ready_r, busy_r;
    logic               accept_s, exec_s;
    logic               exec_we_s;
    logic [WORD_W-1:0]  exec_addr_s, exec_wdata_s, offset_s, ram_rdata_s;
    logic [LANES-1:0]   exec_be_s, wr_en_s;
    logic               fault_s;
    logic [AW-1:0]      idx_s;

    // Select execute operands: live request when executing on the accept edge, captured copy otherwise
    always_comb begin
        if (state_r == IDLE) begin
            exec_we_s    = req_we;
            exec_addr_s  = req_addr;
            exec_wdata_s = req_wdata;
            exec_be_s    = req_be;
        end else begin
            exec_we_s    = we_r;
            exec_addr_s  = addr_r;
            exec_wdata_s = wdata_r;
            exec_be_s    = be_r;
        end
        offset_s = exec_addr_s - BASE_ADDR;
        fault_s  = (exec_addr_s[1:0] != 2'b00) || (offset_s >= SPAN);
        idx_s    = offset_s[AW+1:2];
    end

    // Byte-lane write enables and the response produced by an execute
    always_comb begin
        if (exec_s && exec_we_s && !fault_s) begin
            wr_en_s = exec_be_s;
        end else begin
            wr_en_s = {LANES{1'b0}};
        end
        exec_rsp_s.err = fault_s;
        if (fault_s || exec_we_s) begin
            exec_rsp_s.rdata = {WORD_W{1'b0}};
        end else begin
            exec_rsp_s.rdata = ram_rdata_s;
        end
    end

    // Next-state, counter and response logic
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        valid_next_s = valid_r;
        rsp_next_s   = rsp_r;
        accept_s     = 1'b0;
        exec_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    accept_s = 1'b1;
                    if (DIRECT) begin
                        exec_s       = 1'b1;
                        state_next_s = RESP;
                        cnt_next_s   = 4'd0;
                        valid_next_s = 1'b1;
                        rsp_next_s   = exec_rsp_s;
                    end else begin
                        state_next_s = WAIT;
                        cnt_next_s   = CNT_LOAD;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                // The edge on which the counter reaches zero is the execute edge
                if (cnt_r <= 4'd1) begin
                    exec_s       = 1'b1;
                    state_next_s = RESP;
                    cnt_next_s   = 4'd0;
                    valid_next_s = 1'b1;
                    rsp_next_s   = exec_rsp_s;
                end else begin
                    cnt_next_s = cnt_r - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next_s = IDLE;
                    valid_next_s = 1'b0;
                    rsp_next_s   = RSP_NONE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = 4'd0;
                valid_next_s = 1'b0;
                rsp_next_s   = RSP_NONE;
            end
        endcase
    end

    // Control and response registers; reset leaves RAM contents untouched
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            valid_r <= 1'b0;
            rsp_r   <= RSP_NONE;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            valid_r <= valid_next_s;
            rsp_r   <= rsp_next_s;
            ready_r <= (state_next_s == IDLE);
            busy_r  <= (state_next_s != IDLE);
        end
    end

    // Capture the request fields on the accept edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_r    <= 1'b0;
            addr_r  <= 32'h0000_0000;
            wdata_r <= 32'h0000_0000;
            be_r    <= 4'h0;
        end else if (accept_s) begin
            we_r    <= req_we;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
            be_r    <= req_be;
        end
    end

    dmem_ram_be #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk   (clk),
        .wr_en (wr_en_s),
        .addr  (idx_s),
        .wdata (exec_wdata_s),
        .rdata (ram_rdata_s)
    );

    assign req_ready = ready_r;
    assign busy      = busy_r;
    assign rsp_valid = valid_r;
    assign rsp_rdata = rsp_r.rdata;
    assign rsp_err   = rsp_r.err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: four instances with LATENCY 1, 2, 4, 15.
module tb_dmem_responder;

    localparam int          NI    = 4;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_2000;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid [NI];
    logic        req_ready [NI];
    logic        req_we    [NI];
    logic [31:0] req_addr  [NI];
    logic [31:0] req_wdata [NI];
    logic [3:0]  req_be    [NI];
    logic        rsp_valid [NI];
    logic        rsp_ready [NI];
    logic [31:0] rsp_rdata [NI];
    logic        rsp_err   [NI];
    logic        busy      [NI];

    exp_t        exp_q [$];
    exp_t        mon_e;
    logic [31:0] model [NI][DEPTH];
    int          vectors     = 0;
    int          miscompares = 0;
    int          cur         = 0;
    int          last_wait   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 15;
        dmem_responder #(
            .DEPTH_WORDS (DEPTH),
            .BASE_ADDR   (BASE),
            .LATENCY     (L)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .req_be    (req_be[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g]),
            .busy      (busy[g])
        );
    end

    function automatic int lat_of(int k);
        case (k)
            0:       return 1;
            1:       return 2;
            2:       return 4;
            default: return 15;
        endcase
    endfunction

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic is_fault(logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a[1:0] != 2'b00) || (off >= 32'(DEPTH * 4));
    endfunction

    // Monitor: every response handshake on the active instance is scored
    always @(negedge clk) begin
        if (!reset && rsp_valid[cur] && rsp_ready[cur]) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL rsp_unexpected: inst %0d returned 0x%08h with nothing expected", cur, rsp_rdata[cur]);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata[cur], mon_e.rdata);
                check("rsp_err", 32'(rsp_err[cur]), 32'(mon_e.err));
            end
        end
    end

    task automatic check_reset_outputs(input int k, input string tag);
        check({tag, "_req_ready"}, 32'(req_ready[k]), 32'd1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid[k]), 32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata[k], 32'd0);
        check({tag, "_rsp_err"}, 32'(rsp_err[k]), 32'd0);
        check({tag, "_busy"}, 32'(busy[k]), 32'd0);
    endtask

    // Issue one transaction starting now (caller is just after a rising edge)
    task automatic xact_now(input int k, input logic we, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [3:0] be, input int stall,
                            input bit use_exp, input logic [31:0] exp_rd, input logic exp_err);
        exp_t        e;
        logic [31:0] off;
        logic [31:0] held;
        int          n;
        bit          seen;
        off     = addr - BASE;
        e.err   = is_fault(addr);
        e.rdata = 32'h0;
        if (!e.err) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) model[k][off[5:2]][8*i +: 8] = wd[8*i +: 8];
                end
            end else begin
                e.rdata = model[k][off[5:2]];
            end
        end
        if (use_exp) begin
            e.rdata = exp_rd;
            e.err   = exp_err;
        end
        exp_q.push_back(e);
        cur          = k;
        rsp_ready[k] = (stall == 0);
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = addr;
        req_wdata[k] = wd;
        req_be[k]    = be;
        @(negedge clk);
        n = 0;
        while (!req_ready[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        last_wait = n;
        if (!req_ready[k]) begin
            check("req_ready_timeout", 32'(req_ready[k]), 32'd1);
        end
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
        req_we[k]    = ~we;
        req_addr[k]  = 32'hFFFF_FFF1;
        req_wdata[k] = 32'h0BAD_0BAD;
        req_be[k]    = 4'hF;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (rsp_valid[k]) seen = 1'b1;
        end
        check("latency", 32'(n), 32'(lat_of(k)));
        if (seen && stall > 0) begin
            held = rsp_rdata[k];
            for (int s = 0; s < stall; s++) begin
                @(posedge clk);
                #1;
                @(negedge clk);
                check("hold_rsp_valid", 32'(rsp_valid[k]), 32'd1);
                check("hold_rsp_rdata", rsp_rdata[k], held);
                check("hold_req_ready", 32'(req_ready[k]), 32'd0);
                check("hold_busy", 32'(busy[k]), 32'd1);
            end
            @(posedge clk);
            #1;
            rsp_ready[k] = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post_req_ready", 32'(req_ready[k]), 32'd1);
        check("post_rsp_valid", 32'(rsp_valid[k]), 32'd0);
        check("post_busy", 32'(busy[k]), 32'd0);
    endtask

    task automatic xact(input int k, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be, input int stall,
                        input bit use_exp, input logic [31:0] exp_rd, input logic exp_err);
        @(posedge clk);
        #1;
        xact_now(k, we, addr, wd, be, stall, use_exp, exp_rd, exp_err);
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < NI; k++) begin
            req_valid[k] = 1'b0;
            req_we[k]    = 1'b0;
            req_addr[k]  = 32'h0;
            req_wdata[k] = 32'h0;
            req_be[k]    = 4'h0;
            rsp_ready[k] = 1'b1;
        end
        #3;
        for (int k = 0; k < NI; k++) check_reset_outputs(k, "reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Known contents in every instance; also sweeps latency 1/2/4/15
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                xact(k, 1'b1, BASE + 32'(4 * i), 32'hA5A5_0000 | (32'(k) << 8) | 32'(i),
                     4'hF, 0, 1'b1, 32'h0, 1'b0);
            end
        end

        // Directed vectors on the LATENCY = 2 instance
        xact(1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'hF,    0, 1'b1, 32'h0000_0000, 1'b0);
        xact(1, 1'b0, 32'h0000_2000, 32'h0,         4'hF,    0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        xact(1, 1'b1, 32'h0000_2000, 32'h1122_3344, 4'b0101, 0, 1'b1, 32'h0000_0000, 1'b0);
        xact(1, 1'b0, 32'h0000_2000, 32'h0,         4'h0,    0, 1'b1, 32'hDE22_BE44, 1'b0);
        xact(1, 1'b0, 32'h0000_2002, 32'h0,         4'hF,    0, 1'b1, 32'h0000_0000, 1'b1);
        xact(1, 1'b1, 32'h0000_2040, 32'hFFFF_FFFF, 4'hF,    0, 1'b1, 32'h0000_0000, 1'b1);
        xact(1, 1'b0, 32'h0000_2000, 32'h0,         4'hF,    0, 1'b1, 32'hDE22_BE44, 1'b0);
        xact(1, 1'b1, 32'h0000_2004, 32'h1234_5678, 4'h0,    0, 1'b1, 32'h0000_0000, 1'b0);
        xact(1, 1'b0, 32'h0000_2004, 32'h0,         4'hF,    0, 1'b1, 32'hA5A5_0101, 1'b0);
        xact(1, 1'b0, 32'h0000_1FFC, 32'h0,         4'hF,    0, 1'b1, 32'h0000_0000, 1'b1);
        xact(1, 1'b0, 32'h0000_2000, 32'h0,         4'hF,    5, 1'b1, 32'hDE22_BE44, 1'b0);

        // Reset while a store waits: outputs drop at once and the store is lost
        @(posedge clk);
        #1;
        cur          = 1;
        rsp_ready[1] = 1'b1;
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_addr[1]  = 32'h0000_2008;
        req_wdata[1] = 32'hCAFE_F00D;
        req_be[1]    = 4'hF;
        @(negedge clk);
        check("wait_req_ready", 32'(req_ready[1]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        check("wait_busy", 32'(busy[1]), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs(1, "rst_wait");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        xact(1, 1'b0, 32'h0000_2008, 32'h0, 4'hF, 0, 1'b1, 32'hA5A5_0102, 1'b0);

        // LATENCY = 1: store executes on accept, survives reset, next request accepted at once
        @(posedge clk);
        #1;
        cur          = 0;
        rsp_ready[0] = 1'b0;
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'h0000_200C;
        req_wdata[0] = 32'h55AA_1234;
        req_be[0]    = 4'hF;
        @(negedge clk);
        check("direct_req_ready", 32'(req_ready[0]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        check("direct_rsp_valid", 32'(rsp_valid[0]), 32'd1);
        model[0][3] = 32'h55AA_1234;
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs(0, "rst_resp");
        @(posedge clk);
        #1;
        reset = 1'b0;
        xact_now(0, 1'b0, 32'h0000_200C, 32'h0, 4'hF, 0, 1'b1, 32'h55AA_1234, 1'b0);
        check("first_accept_wait", 32'(last_wait), 32'd0);

        // Random traffic with response stalls, scored against the reference memory
        for (int r = 0; r < 20; r++) begin
            int          k;
            logic [31:0] a;
            k = int'($urandom_range(0, 3));
            a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 7) == 0) a = a + 32'd2;
            if ($urandom_range(0, 9) == 0) a = a + 32'(DEPTH * 4);
            xact(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                 int'($urandom_range(0, 3)), 1'b0, 32'h0, 1'b0);
        end

        repeat (3) @(posedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
